// File: rtl/phase2b_pkg.sv
// Shared types and phase-selection helpers for the 2-bit phase scheduler.
package phase2b_pkg;

    localparam int unsigned PHASES = 4;

    typedef enum logic [0:0] {S_IDLE, S_EMIT} sched_state_t;
    typedef logic [1:0] phase_k_t;
    typedef logic [PHASES-1:0] phase_mask_t;

    typedef struct packed {
        logic     none;
        phase_k_t k;
    } phase_sel_t;

    // Lowest enabled phase strictly above k; none=1 when k is the final phase.
    function automatic phase_sel_t next_phase(input phase_mask_t mask, input phase_k_t k);
        phase_sel_t sel;
        sel.none = 1'b1;
        sel.k    = '0;
        for (int i = PHASES - 1; i >= 0; i--) begin
            if (i > int'(k) && mask[i]) begin
                sel.none = 1'b0;
                sel.k    = phase_k_t'(i);
            end
        end
        return sel;
    endfunction

    function automatic phase_k_t first_phase(input phase_mask_t mask);
        phase_k_t k;
        k = '0;
        for (int i = PHASES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                k = phase_k_t'(i);
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/phase2b_scheduler_rot.sv
// Partial barrel rotator: right-rotates a word by 0..3 bit positions.
module phase2b_scheduler_rot
    import phase2b_pkg::*;
#(
    parameter int unsigned BITSTREAM = 64
) (
    input  logic [BITSTREAM-1:0] bits,
    input  phase_k_t             k,
    output logic [BITSTREAM-1:0] rotated
);

    always_comb begin
        rotated = bits;
        unique case (k)
            2'd0: rotated = bits;
            2'd1: rotated = {bits[0],   bits[BITSTREAM-1:1]};
            2'd2: rotated = {bits[1:0], bits[BITSTREAM-1:2]};
            2'd3: rotated = {bits[2:0], bits[BITSTREAM-1:3]};
            default: rotated = bits;
        endcase
    end

endmodule

// File: rtl/phase2b_scheduler.sv
// Buffers one bitstream word and emits its enabled phase rotations in ascending k order.
module phase2b_scheduler
    import phase2b_pkg::*;
#(
    parameter int unsigned BITSTREAM = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BITSTREAM-1:0] in_bits,
    input  logic [3:0]           in_mask,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BITSTREAM-1:0] out_bits,
    output logic [1:0]           out_k,
    output logic                 out_last,
    output logic [CNT_W-1:0]     word_cnt
);

    sched_state_t           state;
    logic [BITSTREAM-1:0]   word_q;
    phase_mask_t            mask_q;
    phase_k_t               k_q;

    phase_sel_t             sel;
    phase_mask_t            mask_eff;
    logic                   emit;
    logic                   out_hs;
    logic                   in_hs;
    logic [BITSTREAM-1:0]   rot_bits;

    phase2b_scheduler_rot #(
        .BITSTREAM(BITSTREAM)
    ) u_rot (
        .bits    (word_q),
        .k       (k_q),
        .rotated (rot_bits)
    );

    // Handshake decode; a final-beat handshake frees the buffer in the same cycle.
    always_comb begin
        sel      = next_phase(mask_q, k_q);
        mask_eff = (in_mask == 4'b0000) ? 4'b0001 : in_mask;
        emit     = (state == S_EMIT);
        out_hs   = emit && out_ready;
        in_ready = !rst && !flush && (!emit || (out_hs && sel.none));
        in_hs    = in_valid && in_ready;
    end

    assign out_valid = emit;
    assign out_k     = k_q;
    assign out_last  = emit && sel.none;
    assign out_bits  = emit ? rot_bits : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            word_q   <= '0;
            mask_q   <= '0;
            k_q      <= '0;
            word_cnt <= '0;
        end else if (flush) begin
            state  <= S_IDLE;
            word_q <= '0;
            mask_q <= '0;
            k_q    <= '0;
        end else begin
            if (out_hs) begin
                if (!sel.none) begin
                    k_q <= sel.k;
                end else begin
                    word_cnt <= word_cnt + CNT_W'(1);
                    state    <= S_IDLE;
                    k_q      <= '0;
                end
            end
            // A new word overrides the return to idle on a final beat.
            if (in_hs) begin
                word_q <= in_bits;
                mask_q <= mask_eff;
                k_q    <= first_phase(mask_eff);
                state  <= S_EMIT;
            end
        end
    end

endmodule
